// File: rtl/cube_pkg.sv
// Shared state encoding and default sizes for the layer scan sequencer.
// S_BLANK exists only when GHOST_BLANK_EN is defined.
package cube_pkg;
  localparam int COLS_DEF   = 64;
  localparam int LAYERS_DEF = 8;
  localparam int LAYER_W    = $clog2(LAYERS_DEF);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_CAPTURE  = 4'd2,
    S_SHIFT    = 4'd3,
    S_WAIT_ACT = 4'd4,
    S_LATCH    = 4'd5,
    S_START    = 4'd6,
    S_ARM      = 4'd7
`ifdef GHOST_BLANK_EN
    , S_BLANK  = 4'd8
`endif
  } scan_state_t;
endpackage

// File: rtl/col_shifter.sv
// Parallel-load serializer: shifts COLS bits MSB first, SCLK_DIV clk cycles per
// ser_clk half-period; data changes only on the falling edge of ser_clk.
module col_shifter #(
  parameter int COLS     = 64,
  parameter int SCLK_DIV = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [COLS-1:0] data,
  output logic            busy,
  output logic            done,
  output logic            ser_data,
  output logic            ser_clk
);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(COLS + 1);

  logic [COLS-1:0] sreg;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            phase;
  logic            tick;

  assign tick     = (div_cnt == '0);
  // Last cycle of the high half of the final bit.
  assign done     = busy && tick && phase && (bit_cnt == BW'(1));
  assign ser_data = busy & sreg[COLS-1];
  assign ser_clk  = busy & phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      busy    <= 1'b0;
    end else if (load) begin
      sreg    <= data;
      div_cnt <= DW'(SCLK_DIV - 1);
      bit_cnt <= BW'(COLS);
      phase   <= 1'b0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (tick) begin
        div_cnt <= DW'(SCLK_DIV - 1);
        phase   <= ~phase;
        if (phase) begin
          sreg    <= sreg << 1;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == BW'(1)) busy <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/layer_scan_sequencer.sv
// Layer scan sequencer: fetch, serialize, latch and start each layer in turn.
// Optional dark interval before latch when GHOST_BLANK_EN is defined.
//
//  state    | meaning
//  IDLE     | not scanning, waits for enable
//  FETCH    | frame-buffer read strobe for current layer
//  CAPTURE  | load read data into the column shifter
//  SHIFT    | serial shift of COLS bits
//  WAIT_ACT | wait for activator done
//  BLANK    | dark cycles before latch (GHOST_BLANK_EN only)
//  LATCH    | ser_latch pulse
//  START    | act_start pulse, frame_done on last layer
//  ARM      | masks act_done, advances layer
module layer_scan_sequencer
  import cube_pkg::*;
#(
  parameter int COLS         = COLS_DEF,
  parameter int LAYERS       = LAYERS_DEF,
  parameter int SCLK_DIV     = 2,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      fb_rd_en,
  output logic [$clog2(LAYERS)-1:0] fb_rd_addr,
  input  logic [COLS-1:0]           fb_rd_data,
  output logic                      ser_data,
  output logic                      ser_clk,
  output logic                      ser_latch,
  output logic                      act_start,
  output logic [$clog2(LAYERS)-1:0] act_layer,
  input  logic                      act_done,
  output logic                      frame_done
);
  localparam int            LW   = $clog2(LAYERS);
  localparam logic [LW-1:0] LAST = LW'(LAYERS - 1);

  scan_state_t   state, state_nxt;
  logic [LW-1:0] layer;
  logic          sh_load, sh_busy, sh_done;

`ifdef GHOST_BLANK_EN
  localparam int BCW = $clog2(BLANK_CYCLES + 1);
  logic [BCW-1:0] blank_cnt;
`endif

  col_shifter #(
    .COLS     (COLS),
    .SCLK_DIV (SCLK_DIV)
  ) u_col_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .data     (fb_rd_data),
    .busy     (sh_busy),
    .done     (sh_done),
    .ser_data (ser_data),
    .ser_clk  (ser_clk)
  );

  assign sh_load    = (state == S_CAPTURE);
  assign fb_rd_en   = (state == S_FETCH);
  assign fb_rd_addr = fb_rd_en ? layer : '0;
  assign ser_latch  = (state == S_LATCH);
  assign act_start  = (state == S_START);
  assign frame_done = act_start && (layer == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (enable) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_CAPTURE;
      S_CAPTURE:  state_nxt = S_SHIFT;
      S_SHIFT:    if (sh_done || !sh_busy) state_nxt = S_WAIT_ACT;
`ifdef GHOST_BLANK_EN
      S_WAIT_ACT: if (act_done) state_nxt = S_BLANK;
      S_BLANK:    if (blank_cnt <= BCW'(1)) state_nxt = S_LATCH;
`else
      S_WAIT_ACT: if (act_done) state_nxt = S_LATCH;
`endif
      S_LATCH:    state_nxt = S_START;
      S_START:    state_nxt = S_ARM;
      S_ARM:      state_nxt = enable ? S_FETCH : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      layer     <= '0;
      act_layer <= '0;
    end else begin
      state <= state_nxt;
      // Loaded one cycle early so act_layer is already valid alongside act_start.
      if (state == S_LATCH) act_layer <= layer;
      if (state == S_ARM) layer <= (layer == LAST) ? '0 : layer + 1'b1;
    end
  end

`ifdef GHOST_BLANK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_cnt <= '0;
    end else if (state == S_WAIT_ACT && act_done) begin
      blank_cnt <= BCW'(BLANK_CYCLES);
    end else if (state == S_BLANK && blank_cnt != '0) begin
      blank_cnt <= blank_cnt - 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_layer_scan_sequencer.sv
// Bench for layer_scan_sequencer: timeline model of the scan plus directed scenarios.
`timescale 1ns/1ps
module tb_layer_scan_sequencer;
  localparam int COLS = 8, LAYERS = 4, SCLK_DIV = 1, BLANK_CYCLES = 5, HOLD = 20;
`ifdef GHOST_BLANK_EN
  localparam int BLANK_EXTRA = BLANK_CYCLES;
`else
  localparam int BLANK_EXTRA = 0;
`endif

  logic            clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic            fb_rd_en, ser_data, ser_clk, ser_latch, act_start, frame_done, act_done;
  logic [1:0]      fb_rd_addr, act_layer;
  logic [COLS-1:0] fb_rd_data = '0;

  always #5 clk = ~clk;

  layer_scan_sequencer #(
    .COLS(COLS), .LAYERS(LAYERS), .SCLK_DIV(SCLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch),
    .act_start(act_start), .act_layer(act_layer), .act_done(act_done),
    .frame_done(frame_done)
  );

  // Frame buffer and activator models
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= 8'hA0 | 8'(fb_rd_addr);

  int   act_cnt = 0;
  logic stuck = 1'b0;
  always @(posedge clk)
    if (!rst_n) act_cnt <= 0;
    else if (act_start) act_cnt <= HOLD + 1;
    else if (act_cnt != 0) act_cnt <= act_cnt - 1;
  assign act_done = !stuck && (act_cnt == 0 || act_cnt == HOLD + 1);

  int cyc = 0;
  bit s_en, s_done, s_rst;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_en   <= enable;
    s_done <= act_done;
    s_rst  <= rst_n;
  end

  int checks = 0, errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: expected outputs for the current cycle
  logic       e_fb, e_sd, e_sc, e_lat, e_st, e_fd;
  logic [1:0] e_addr, e_al;
  int         m_layer;

  task automatic m_cycle(output bit ab);
    @(posedge clk); #1;
    e_fb = 0; e_addr = 0; e_sd = 0; e_sc = 0; e_lat = 0; e_st = 0; e_fd = 0;
    ab = !s_rst;
    if (ab) begin m_layer = 0; e_al = 0; end
  endtask

  task automatic run_layer(output bit go);
    bit ab;
    logic [7:0] word;
    go = 0;
    word = 8'hA0 | 8'(m_layer);
    e_fb = 1; e_addr = 2'(m_layer);
    m_cycle(ab); if (ab) return;
    for (int i = 0; i < 2 * SCLK_DIV * COLS; i++) begin
      m_cycle(ab); if (ab) return;
      e_sc = 1'((i / SCLK_DIV) % 2);
      e_sd = word[COLS - 1 - i / (2 * SCLK_DIV)];
    end
    m_cycle(ab); if (ab) return;
    forever begin
      m_cycle(ab); if (ab) return;
      if (s_done) break;
    end
    repeat (BLANK_EXTRA) begin m_cycle(ab); if (ab) return; end
    e_lat = 1;
    m_cycle(ab); if (ab) return;
    e_st = 1; e_al = 2'(m_layer); e_fd = (m_layer == LAYERS - 1);
    m_cycle(ab); if (ab) return;
    m_layer = (m_layer + 1) % LAYERS;
    m_cycle(ab); if (ab) return;
    go = s_en;
  endtask

  initial begin : model
    bit ab, go;
    m_layer = 0; e_al = 0;
    e_fb = 0; e_addr = 0; e_sd = 0; e_sc = 0; e_lat = 0; e_st = 0; e_fd = 0;
    forever begin
      m_cycle(ab);
      if (!ab && s_en) begin
        go = 1;
        while (go) run_layer(go);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("fb_rd_en",   32'(fb_rd_en),   32'(e_fb));
        chk("fb_rd_addr", 32'(fb_rd_addr), 32'(e_addr));
        chk("ser_data",   32'(ser_data),   32'(e_sd));
        chk("ser_clk",    32'(ser_clk),    32'(e_sc));
        chk("ser_latch",  32'(ser_latch),  32'(e_lat));
        chk("act_start",  32'(act_start),  32'(e_st));
        chk("act_layer",  32'(act_layer),  32'(e_al));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
      end
    end
  end

  // Event recorder for the hand-computed expectations
  int         fetch_q[$], lat_cyc_q[$], start_cyc_q[$], rise_q[$];
  logic [7:0] lat_bits_q[$];
  int         frame_cnt = 0;

  initial begin : monitor
    logic [7:0] cur_bits;
    int rises, last_latch;
    logic prev_sc;
    cur_bits = 0; rises = 0; last_latch = -10; prev_sc = 0;
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        if (fb_rd_en) begin fetch_q.push_back(int'(fb_rd_addr)); cur_bits = 0; rises = 0; end
        if (ser_clk && !prev_sc) begin cur_bits = {cur_bits[6:0], ser_data}; rises++; end
        prev_sc = ser_clk;
        if (ser_latch) begin
          last_latch = cyc;
          lat_cyc_q.push_back(cyc);
          lat_bits_q.push_back(cur_bits);
          rise_q.push_back(rises);
        end
        if (act_start) begin
          start_cyc_q.push_back(cyc);
          chk("latch_to_start", 32'(cyc - last_latch), 32'd1);
        end
        if (frame_done) begin
          frame_cnt++;
          chk("frame_done_layer", 32'(act_layer), 32'd3);
          chk("frame_done_with_start", 32'(act_start), 32'd1);
        end
      end
    end
  end

  task automatic wait_fetches(input int n, input int budget);
    int k = 0;
    while (fetch_q.size() < n && k < budget) begin @(negedge clk); k++; end
    chk("fetch_wait", 32'(fetch_q.size() >= n), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int exp_addr[7];
    int n_lat;
    exp_addr = '{0, 1, 2, 3, 0, 1, 2};
    @(posedge clk); cmp_on = 1;
    idle(3);
    rst_n = 1;
    idle(12);
    chk("idle_no_fetch", 32'(fetch_q.size()), 32'd0);

    enable = 1;
    wait_fetches(7, 1200);
    idle(5);
    enable = 0;
    idle(100);
    chk("fetch_count_after_stop", 32'(fetch_q.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < fetch_q.size()) chk($sformatf("fetch_addr_%0d", i), 32'(fetch_q[i]), 32'(exp_addr[i]));
    chk("start_count", 32'(start_cyc_q.size()), 32'd7);
    chk("frame_count", 32'(frame_cnt), 32'd1);
    chk("act_layer_held_idle", 32'(act_layer), 32'd2);
    if (lat_bits_q.size() >= 4) begin
      chk("layer0_bits", 32'(lat_bits_q[0]), 32'hA0);
      chk("layer3_bits", 32'(lat_bits_q[3]), 32'hA3);
      chk("layer0_rises", 32'(rise_q[0]), 32'd8);
      chk("l1_latch_after_l0_start", 32'(lat_cyc_q[1] - start_cyc_q[0]), 32'(23 + BLANK_EXTRA));
    end else begin
      chk("latch_count", 32'(lat_bits_q.size()), 32'd7);
    end

    stuck = 1; enable = 1;
    wait_fetches(8, 200);
    n_lat = lat_cyc_q.size();
    idle(60);
    chk("stall_no_latch", 32'(lat_cyc_q.size()), 32'(n_lat));
    if (fetch_q.size() >= 8) chk("resume_addr", 32'(fetch_q[7]), 32'd3);

    rst_n = 0; idle(2);
    stuck = 0; rst_n = 1;
    wait_fetches(9, 50);
    if (fetch_q.size() >= 9) chk("after_reset_addr", 32'(fetch_q[8]), 32'd0);
    idle(6);
    rst_n = 0;
    @(negedge clk);
    chk("reset_ser_clk", 32'(ser_clk), 32'd0);
    chk("reset_ser_data", 32'(ser_data), 32'd0);
    chk("reset_act_layer", 32'(act_layer), 32'd0);
    rst_n = 1;
    wait_fetches(10, 50);
    if (fetch_q.size() >= 10) chk("restart_addr", 32'(fetch_q[9]), 32'd0);
    idle(30);
    enable = 0;
    idle(100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
